spi_flash_responder: RTL and testbench

SPI-flash target model. It answers the SPI master on the flash pins (SCK/CSn/MOSI/MISO) with a byte-addressed internal memory image. It is the other end of the flash link: it stands in for the external serial flash in simulation and on boards without one, so the flash boot and programming paths can run unchanged. It oversamples the SPI pins in the system clock domain, which makes it fully synchronous.

---
 rtl/spi_flash_responder.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: serial-flash target model answering an SPI mode-0
// master from a byte-addressed memory image. All SPI pins are oversampled
// in the wb_clk domain, so the block is fully synchronous.
//
// Supported commands: 0x03 READ, 0x9F RDID.
// Optional build macro SPI_FLASH_PP_EN adds 0x06 WREN, 0x02 PP (page
// program, wraps within a 256-byte page) and 0x05 RDSR. Without it those
// codes are ignored like any other unknown command and the image is read-only.
//
// memsize must be a power of two and at least 256.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | deselected, waiting for CSn to fall
// S_CMD    | shifting in the 8-bit command
// S_ADDR   | shifting in the 24-bit address (low bits kept)
// S_DATA   | streaming mem[addr++] out on MISO
// S_ID     | streaming JEDEC ID bytes (or status byte for RDSR)
// S_IGNORE | command not handled (or WREN done), wait for CSn high
// S_PROG   | page-program data bytes written to the image (PP builds only)

module spi_flash_responder #(
    parameter int          memsize   = 8192,
    parameter string       INIT_FILE = "",
    parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
    input  logic wb_clk,
    input  logic wb_rst,
    input  logic i_SCK,
    input  logic i_CSn,
    input  logic i_MOSI,
    output logic o_MISO,
    output logic o_MISO_en,
    output logic o_active
);

    localparam int AW = $clog2(memsize);
`ifdef SPI_FLASH_PP_EN
    localparam logic [AW-1:0] PAGE_LO = AW'(255);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_ID,
        S_IGNORE
`ifdef SPI_FLASH_PP_EN
        , S_PROG
`endif
    } state_t;

    state_t state, state_nxt;

    logic sck_m, sck_s, sck_d;
    logic csn_m, csn_s, csn_d;
    logic mosi_m, mosi_s;
    logic sck_rise, sck_fall, csn_fall;

    logic [4:0]    bit_cnt, bit_cnt_nxt;
    logic [6:0]    rx_sr, rx_nxt;
    logic [6:0]    tx_sr, tx_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [1:0]    id_idx, id_idx_nxt;
    logic          miso_nxt, en_nxt, active_nxt;
    logic [7:0]    rx_byte;
    logic [7:0]    src_byte;
    logic [7:0]    mem_q;

`ifdef SPI_FLASH_PP_EN
    logic wel, wel_nxt;
    logic wren_pend, wren_pend_nxt;
    logic pp_seen, pp_seen_nxt;
    logic st_sel, st_sel_nxt;
    logic mem_we;
`endif

    logic [7:0] mem [memsize];

    // Image preload: zero-fill.
    initial begin
        for (int i = 0; i < memsize; i++) mem[i] = 8'h00;
    end

    // Two-flop synchronizers plus a previous-value flop for edge detect.
    // CSn chain resets low so a master already holding CSn low after reset
    // does not look like a new selection; it must go high first.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            sck_m  <= 1'b0;
            sck_s  <= 1'b0;
            sck_d  <= 1'b0;
            csn_m  <= 1'b0;
            csn_s  <= 1'b0;
            csn_d  <= 1'b0;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
        end else begin
            sck_m  <= i_SCK;
            sck_s  <= sck_m;
            sck_d  <= sck_s;
            csn_m  <= i_CSn;
            csn_s  <= csn_m;
            csn_d  <= csn_s;
            mosi_m <= i_MOSI;
            mosi_s <= mosi_m;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign csn_fall = ~csn_s & csn_d;
    assign rx_byte  = {rx_sr, mosi_s};

    // Select the byte to start shifting out at a byte boundary.
    always_comb begin
        src_byte = mem_q;
        if (state == S_ID) begin
            case (id_idx)
                2'd0:    src_byte = JEDEC_ID[23:16];
                2'd1:    src_byte = JEDEC_ID[15:8];
                2'd2:    src_byte = JEDEC_ID[7:0];
                default: src_byte = 8'h00;
            endcase
`ifdef SPI_FLASH_PP_EN
            if (st_sel) src_byte = {6'b0, wel, 1'b0};
`endif
        end
    end

    // Next-state and datapath decode; a high CSn overrides any SCK edge.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        rx_nxt      = rx_sr;
        tx_nxt      = tx_sr;
        addr_nxt    = addr;
        id_idx_nxt  = id_idx;
        miso_nxt    = o_MISO;
        en_nxt      = o_MISO_en;
        active_nxt  = o_active;
`ifdef SPI_FLASH_PP_EN
        wel_nxt       = wel;
        wren_pend_nxt = wren_pend;
        pp_seen_nxt   = pp_seen;
        st_sel_nxt    = st_sel;
        mem_we        = 1'b0;
`endif
        if (csn_s) begin
            state_nxt   = S_IDLE;
            bit_cnt_nxt = '0;
            rx_nxt      = '0;
            miso_nxt    = 1'b0;
            en_nxt      = 1'b0;
            active_nxt  = 1'b0;
`ifdef SPI_FLASH_PP_EN
            // Write enable latches only once WREN is fully deselected;
            // any PP that got past its command byte consumes it.
            if (wren_pend) wel_nxt = 1'b1;
            if (pp_seen)   wel_nxt = 1'b0;
            wren_pend_nxt = 1'b0;
            pp_seen_nxt   = 1'b0;
            st_sel_nxt    = 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (csn_fall) begin
                        state_nxt   = S_CMD;
                        bit_cnt_nxt = '0;
                        active_nxt  = 1'b1;
                    end
                end
                S_CMD: begin
                    if (sck_rise) begin
                        rx_nxt      = rx_byte[6:0];
                        bit_cnt_nxt = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt_nxt = '0;
                            state_nxt   = S_IGNORE;
                            active_nxt  = 1'b0;
                            case (rx_byte)
                                8'h03: begin
                                    state_nxt  = S_ADDR;
                                    active_nxt = 1'b1;
                                end
                                8'h9F: begin
                                    state_nxt  = S_ID;
                                    active_nxt = 1'b1;
                                    id_idx_nxt = 2'd0;
                                end
`ifdef SPI_FLASH_PP_EN
                                8'h06: begin
                                    // Nothing more to shift; park until CSn rises.
                                    active_nxt    = 1'b1;
                                    wren_pend_nxt = 1'b1;
                                end
                                8'h02: begin
                                    if (wel) begin
                                        state_nxt   = S_ADDR;
                                        active_nxt  = 1'b1;
                                        pp_seen_nxt = 1'b1;
                                    end
                                end
                                8'h05: begin
                                    state_nxt  = S_ID;
                                    active_nxt = 1'b1;
                                    st_sel_nxt = 1'b1;
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    // Shifting straight into addr drops the bits above memsize.
                    if (sck_rise) begin
                        addr_nxt    = {addr[AW-2:0], mosi_s};
                        bit_cnt_nxt = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt_nxt = '0;
                            state_nxt   = S_DATA;
`ifdef SPI_FLASH_PP_EN
                            if (pp_seen) state_nxt = S_PROG;
`endif
                        end
                    end
                end
                S_DATA, S_ID: begin
                    if (sck_fall) begin
                        en_nxt = 1'b1;
                        if (bit_cnt == 5'd0) begin
                            miso_nxt = src_byte[7];
                            tx_nxt   = src_byte[6:0];
                        end else begin
                            miso_nxt = tx_sr[6];
                            tx_nxt   = {tx_sr[5:0], 1'b0};
                        end
                        if (bit_cnt == 5'd7) begin
                            bit_cnt_nxt = '0;
                            if (state == S_DATA) addr_nxt = addr + AW'(1);
                            else if (id_idx != 2'd3) id_idx_nxt = id_idx + 2'd1;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 5'd1;
                        end
                    end
                end
`ifdef SPI_FLASH_PP_EN
                S_PROG: begin
                    if (sck_rise) begin
                        rx_nxt      = rx_byte[6:0];
                        bit_cnt_nxt = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt_nxt = '0;
                            mem_we      = 1'b1;
                            addr_nxt    = (addr & ~PAGE_LO) | ((addr + AW'(1)) & PAGE_LO);
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Datapath and output registers.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            addr      <= '0;
            id_idx    <= '0;
            o_MISO    <= 1'b0;
            o_MISO_en <= 1'b0;
            o_active  <= 1'b0;
`ifdef SPI_FLASH_PP_EN
            wel       <= 1'b0;
            wren_pend <= 1'b0;
            pp_seen   <= 1'b0;
            st_sel    <= 1'b0;
`endif
        end else begin
            bit_cnt   <= bit_cnt_nxt;
            rx_sr     <= rx_nxt;
            tx_sr     <= tx_nxt;
            addr      <= addr_nxt;
            id_idx    <= id_idx_nxt;
            o_MISO    <= miso_nxt;
            o_MISO_en <= en_nxt;
            o_active  <= active_nxt;
`ifdef SPI_FLASH_PP_EN
            wel       <= wel_nxt;
            wren_pend <= wren_pend_nxt;
            pp_seen   <= pp_seen_nxt;
            st_sel    <= st_sel_nxt;
`endif
        end
    end

    // Image port: registered read of mem[addr] every cycle, plus PP writes.
    always_ff @(posedge wb_clk) begin
`ifdef SPI_FLASH_PP_EN
        if (mem_we && !wb_rst) mem[addr] <= rx_byte;
`endif
        mem_q <= mem[addr];
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: bit-banged SPI mode-0 master, with a
// byte-array reference image of the flash contents.
module tb_spi_flash_responder;

    localparam int          MEMSIZE = 8192;
    localparam logic [23:0] JEDEC   = 24'hEF4016;

    logic wb_clk = 1'b0;
    logic wb_rst = 1'b1;
    logic i_SCK  = 1'b0;
    logic i_CSn  = 1'b1;
    logic i_MOSI = 1'b0;
    logic o_MISO, o_MISO_en, o_active;

    int tests = 0;
    int fails = 0;

    logic [7:0] model_mem [MEMSIZE];
    logic en_any, en_all;

    always #5 wb_clk = ~wb_clk;

    spi_flash_responder #(.memsize(MEMSIZE)) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .i_SCK     (i_SCK),
        .i_CSn     (i_CSn),
        .i_MOSI    (i_MOSI),
        .o_MISO    (o_MISO),
        .o_MISO_en (o_MISO_en),
        .o_active  (o_active)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    task automatic poke(input int a, input logic [7:0] v);
        model_mem[a] = v;
        dut.mem[a]   = v;
    endtask

    // Shift nbits MSB-first; MISO/en sampled just before each rising SCK.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            i_MOSI = tx[i];
            wait_clk(5);
            rx[i]  = o_MISO;
            en_any = en_any | o_MISO_en;
            en_all = en_all & o_MISO_en;
            i_SCK  = 1'b1;
            wait_clk(5);
            i_SCK  = 1'b0;
        end
    endtask

    task automatic cs_start();
        i_CSn = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_end();
        wait_clk(4);
        i_CSn = 1'b1;
        wait_clk(6);
    endtask

    task automatic read_seq(input logic [23:0] a, input int n, input string tag);
        logic [7:0] rx;
        int base;
        base = int'(a) % MEMSIZE;
        cs_start();
        en_any = 1'b0;
        spi_bits(8'h03, 8, rx);
        spi_bits(a[23:16], 8, rx);
        spi_bits(a[15:8], 8, rx);
        spi_bits(a[7:0], 8, rx);
        check({tag, "_hdr_en"}, en_any, 1'b0);
        check({tag, "_active"}, o_active, 1'b1);
        en_all = 1'b1;
        for (int i = 0; i < n; i++) begin
            spi_bits(8'h00, 8, rx);
            check($sformatf("%s_b%0d", tag, i), rx, model_mem[(base + i) % MEMSIZE]);
        end
        check({tag, "_data_en"}, en_all, 1'b1);
        cs_end();
        check({tag, "_end_en"}, o_MISO_en, 1'b0);
        check({tag, "_end_active"}, o_active, 1'b0);
    endtask

    initial begin
        logic [7:0]  rx;
        logic [23:0] ra;
        logic [7:0]  id_exp [4];
        logic        pp_on;
`ifdef SPI_FLASH_PP_EN
        pp_on = 1'b1;
`else
        pp_on = 1'b0;
`endif
        en_any = 1'b0;
        en_all = 1'b1;

        wait_clk(3);
        wb_rst = 1'b0;
        wait_clk(1);
        check("rst_miso", o_MISO, 1'b0);
        check("rst_en", o_MISO_en, 1'b0);
        check("rst_active", o_active, 1'b0);

        for (int i = 0; i < MEMSIZE; i++) poke(i, 8'($urandom));
        poke(16'h0010, 8'h11);
        poke(16'h0011, 8'h22);
        poke(16'h0012, 8'h33);
        poke(16'h0013, 8'h44);
        poke(16'h1FFF, 8'hAA);
        poke(16'h0000, 8'h55);

        read_seq(24'h000010, 4, "rd10");
        read_seq(24'h001FFF, 2, "wrap");
        read_seq(24'hFF1FFF, 1, "hidrop");

        // RDID
        id_exp = '{JEDEC[23:16], JEDEC[15:8], JEDEC[7:0], 8'h00};
        cs_start();
        spi_bits(8'h9F, 8, rx);
        en_all = 1'b1;
        for (int i = 0; i < 4; i++) begin
            spi_bits(8'h00, 8, rx);
            check($sformatf("rdid_b%0d", i), rx, id_exp[i]);
        end
        check("rdid_en", en_all, 1'b1);
        cs_end();

        // Unknown command: ignored until deselect.
        cs_start();
        spi_bits(8'hAB, 8, rx);
        check("ign_active", o_active, 1'b0);
        en_any = 1'b0;
        spi_bits(8'hFF, 8, rx);
        check("ign_miso0", rx, 8'h00);
        spi_bits(8'hFF, 8, rx);
        check("ign_miso1", rx, 8'h00);
        check("ign_en", en_any, 1'b0);
        cs_end();
        read_seq(24'h000010, 1, "after_ign");

        // Deselect after 12 address bits, then a clean read.
        cs_start();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 4, rx);
        cs_end();
        read_seq(24'h000011, 1, "after_part");

        // Reset pulse during the data phase.
        cs_start();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h10, 8, rx);
        spi_bits(8'h00, 8, rx);
        check("mid_b0", rx, 8'h11);
        spi_bits(8'h00, 3, rx);
        check("mid_en_before", o_MISO_en, 1'b1);
        wb_rst = 1'b1;
        wait_clk(1);
        wb_rst = 1'b0;
        check("midrst_miso", o_MISO, 1'b0);
        check("midrst_en", o_MISO_en, 1'b0);
        check("midrst_active", o_active, 1'b0);
        en_any = 1'b0;
        spi_bits(8'h03, 8, rx);
        check("midrst_no_restart_en", en_any, 1'b0);
        check("midrst_no_restart_act", o_active, 1'b0);
        cs_end();
        read_seq(24'h000012, 1, "after_rst");

        // Randomized reads against the reference image.
        for (int k = 0; k < 6; k++) begin
            ra = 24'($urandom);
            read_seq(ra, $urandom_range(4, 1), $sformatf("rnd%0d", k));
        end

        // WREN, RDSR, PP with page wrap, RDSR, read back.
        cs_start();
        spi_bits(8'h06, 8, rx);
        cs_end();
        cs_start();
        spi_bits(8'h05, 8, rx);
        en_all = 1'b1;
        spi_bits(8'h00, 8, rx);
        check("rdsr_wel", rx, pp_on ? 8'h02 : 8'h00);
        check("rdsr_wel_en", en_all, pp_on);
        cs_end();

        cs_start();
        spi_bits(8'h02, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'hFE, 8, rx);
        spi_bits(8'h01, 8, rx);
        spi_bits(8'h02, 8, rx);
        spi_bits(8'h03, 8, rx);
        spi_bits(8'hC5, 5, rx);
        cs_end();
        if (pp_on) begin
            model_mem[8'hFE] = 8'h01;
            model_mem[8'hFF] = 8'h02;
            model_mem[0]     = 8'h03;
        end

        cs_start();
        spi_bits(8'h05, 8, rx);
        en_all = 1'b1;
        spi_bits(8'h00, 8, rx);
        check("rdsr_after_pp", rx, 8'h00);
        spi_bits(8'h00, 8, rx);
        check("rdsr_repeat", rx, 8'h00);
        check("rdsr_after_en", en_all, pp_on);
        cs_end();

        read_seq(24'h0000FE, 3, "pp_rd");
        read_seq(24'h000000, 1, "pp_wrap");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
